// File: rtl/bch_syndrome_serial.sv
// Serial BCH syndrome generator: accepts one codeword bit per cycle (highest
// degree first) and produces S1..S2T over GF(2^M) through a one-deep output
// register with a valid/ready handshake.
// Optional feature macro: BCH_SYNDROME_NONZERO_EN adds a registered 'nonzero'
// flag that is set whenever any delivered syndrome is non-zero.
module bch_syndrome_serial #(
    parameter int          M    = 4,
    parameter int          T    = 2,
    parameter int          N    = 15,
    parameter int unsigned POLY = 32'h13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               start,
    input  logic               ready,
    output logic [2*T*M-1:0]   syndromes
`ifdef BCH_SYNDROME_NONZERO_EN
    ,
    output logic               nonzero
`endif
);

    localparam int             SW       = 2 * T * M;
    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [M-1:0]   POLY_LO  = POLY[M-1:0];

    localparam logic [0:0] ST_ACCUM   = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Multiply a field element by alpha: shift up and fold x^M back via POLY.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
        logic [M-1:0] r;
        r = {x[M-2:0], 1'b0};
        if (x[M-1]) begin
            r = r ^ POLY_LO;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Multiply a field element by alpha^j (j in 1..2T) as j repeated steps.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x, input int j);
        logic [M-1:0] r;
        r = x;
        for (int k = 0; k < 2 * T; k++) begin
            if (k < j) begin
                r = mul_alpha(r);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [SW-1:0] acc_q, acc_d, acc_next_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic          start_q, start_d;
    logic          in_ready_q, in_ready_d;
    logic [SW-1:0] syn_q, syn_d;
    logic          accept_s, last_s, drain_s, out_free_s, load_s;
`ifdef BCH_SYNDROME_NONZERO_EN
    logic          nonzero_q, nonzero_d;
`endif

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign syndromes = syn_q;
`ifdef BCH_SYNDROME_NONZERO_EN
    assign nonzero   = nonzero_q;
`endif

    // Horner step for every accumulator: Sj*alpha^j xor incoming bit.
    always_comb begin
        acc_next_s = '0;
        for (int j = 1; j <= 2 * T; j++) begin
            acc_next_s[(j-1)*M +: M] = mul_alpha_pow(acc_q[(j-1)*M +: M], j)
                                     ^ {{(M-1){1'b0}}, in_bit};
        end
    end

    // Handshake decode: the output register is free when empty or draining now.
    always_comb begin
        accept_s   = in_valid && (state_q == ST_ACCUM);
        last_s     = (cnt_q == CNT_LAST);
        drain_s    = start_q && ready;
        out_free_s = !start_q || ready;
    end

    // Accumulator/counter state machine and output-register load decision.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        syn_d   = syn_q;
        load_s  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    if (last_s) begin
                        cnt_d = '0;
                        if (out_free_s) begin
                            syn_d  = acc_next_s;
                            load_s = 1'b1;
                            acc_d  = '0;
                        end else begin
                            // Output busy: park the finished values here.
                            acc_d   = acc_next_s;
                            state_d = ST_PENDING;
                        end
                    end else begin
                        acc_d = acc_next_s;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_PENDING: begin
                if (out_free_s) begin
                    syn_d   = acc_q;
                    load_s  = 1'b1;
                    acc_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Output valid flag and input-ready flag, both derived from next state.
    always_comb begin
        if (load_s) begin
            start_d = 1'b1;
        end else if (drain_s) begin
            start_d = 1'b0;
        end else begin
            start_d = start_q;
        end
        in_ready_d = (state_d == ST_ACCUM);
    end

`ifdef BCH_SYNDROME_NONZERO_EN
    // Non-zero flag follows whatever result is loaded into the output register.
    always_comb begin
        if (load_s) begin
            nonzero_d = |syn_d;
        end else begin
            nonzero_d = nonzero_q;
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_ACCUM;
            start_q    <= 1'b0;
            in_ready_q <= 1'b1;
            syn_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            start_q    <= start_d;
            in_ready_q <= in_ready_d;
            syn_q      <= syn_d;
        end
    end

`ifdef BCH_SYNDROME_NONZERO_EN
    // Non-zero flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nonzero_q <= 1'b0;
        end else begin
            nonzero_q <= nonzero_d;
        end
    end
`endif

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// Self-checking bench for bch_syndrome_serial (M=4, T=2, N=15, POLY=0x13).
// The reference evaluates the received polynomial at alpha^j from a power
// table and tracks the result queue/handshake at transaction level.
module tb_bch_syndrome_serial;

    localparam int M  = 4;
    localparam int T  = 2;
    localparam int N  = 15;
    localparam int POLY = 32'h13;
    localparam int SW = 2 * T * M;
    localparam int QN = (1 << M) - 1;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          start;
    logic          ready;
    logic [SW-1:0] syndromes;
`ifdef BCH_SYNDROME_NONZERO_EN
    logic          nonzero;
`endif

    int checks = 0;
    int errors = 0;
    bit rnd_ready = 1'b0;

    bch_syndrome_serial dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .start     (start),
        .ready     (ready),
        .syndromes (syndromes)
`ifdef BCH_SYNDROME_NONZERO_EN
        ,
        .nonzero   (nonzero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Syndromes of a word given in arrival order (w[0] is the x^(N-1) coefficient).
    function automatic logic [SW-1:0] eval_word(input logic [N-1:0] w);
        int ex [QN];
        int v;
        int s;
        logic [SW-1:0] res;
        v = 1;
        for (int i = 0; i < QN; i++) begin
            ex[i] = v;
            v = v << 1;
            if ((v & (1 << M)) != 0) v = v ^ POLY;
        end
        res = '0;
        for (int j = 1; j <= 2 * T; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                if (w[i]) s = s ^ ex[(j * (N - 1 - i)) % QN];
            res[(j-1)*M +: M] = s[M-1:0];
        end
        return res;
    endfunction

    // Transaction-level reference state.
    bit            m_full = 1'b0;
    bit            m_pend = 1'b0;
    logic [SW-1:0] m_out  = '0;
    logic [SW-1:0] m_pval = '0;
    logic [N-1:0]  m_bits = '0;
    int            m_cnt  = 0;
    bit            seen_rst = 1'b0;

    // Reference update at each edge, then compare DUT outputs 1 time unit later.
    initial begin
        logic v, b, r, rn, acc, drain, free, loaded;
        logic [SW-1:0] res;
        forever begin
            @(posedge clk);
            v = in_valid; b = in_bit; r = ready; rn = reset_n;
            #1;
            if (!rn) begin
                seen_rst = 1'b1;
                m_full = 1'b0; m_pend = 1'b0; m_out = '0; m_cnt = 0; m_bits = '0;
            end else begin
                acc    = v && !m_pend;
                drain  = m_full && r;
                free   = !m_full || r;
                loaded = 1'b0;
                if (acc) begin
                    m_bits[m_cnt] = b;
                    m_cnt++;
                    if (m_cnt == N) begin
                        res   = eval_word(m_bits);
                        m_cnt = 0;
                        if (free) begin
                            m_out = res; loaded = 1'b1;
                        end else begin
                            m_pval = res; m_pend = 1'b1;
                        end
                    end
                end else if (m_pend && free) begin
                    m_out = m_pval; m_pend = 1'b0; loaded = 1'b1;
                end
                if (loaded) m_full = 1'b1;
                else if (drain) m_full = 1'b0;
            end
            if (seen_rst) begin
                chk("start", start, m_full);
                chk("in_ready", in_ready, !m_pend);
                chk("syndromes", syndromes, m_out);
`ifdef BCH_SYNDROME_NONZERO_EN
                chk("nonzero", nonzero, |m_out);
`endif
            end
        end
    end

    // Optional randomized downstream ready.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present one bit until it is accepted (bounded wait).
    task automatic drive_bit(input logic b);
        logic ok;
        int budget;
        in_valid = 1'b1;
        in_bit   = b;
        budget   = 0;
        forever begin
            ok = in_ready;
            cyc();
            budget++;
            if (ok) break;
            if (budget > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) cyc();
            end
            drive_bit(w[i]);
        end
    endtask

    logic [N-1:0] wa, wb, wg;

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        ready    = 1'b0;
        repeat (3) cyc();
        chk("rst_start", start, 1'b0);
        chk("rst_syndromes", syndromes, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        ready   = 1'b1;

        // Pin the reference against hand-computed values.
        chk("model_first_bit", eval_word(15'h0001), 16'hEFD9);
        chk("model_last_bit", eval_word(15'h4000), 16'h1111);
        chk("model_zero", eval_word(15'h0000), 16'h0000);

        // All-zero word: start one cycle after the 15th bit, zero syndromes.
        send_word(15'h0000, 1'b0);
        chk("zero_start", start, 1'b1);
        chk("zero_syn", syndromes, 16'h0000);

        // Single 1 on the first bit.
        send_word(15'h0001, 1'b0);
        chk("first_start", start, 1'b1);
        chk("first_syn", syndromes, 16'hEFD9);
`ifdef BCH_SYNDROME_NONZERO_EN
        chk("first_nonzero", nonzero, 1'b1);
`endif

        // Single 1 on the last bit.
        send_word(15'h4000, 1'b0);
        chk("last_syn", syndromes, 16'h1111);
        cyc();
        chk("drained", start, 1'b0);
        chk("held_syn", syndromes, 16'h1111);

        // Back-pressure: two words back-to-back with ready low.
        ready = 1'b0;
        wa = N'($urandom());
        wb = N'($urandom());
        send_word(wa, 1'b0);
        send_word(wb, 1'b0);
        repeat (3) cyc();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_start", start, 1'b1);
        chk("bp_first_held", syndromes, eval_word(wa));
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        chk("bp_no_bubble", start, 1'b1);
        chk("bp_second_loaded", syndromes, eval_word(wb));
        chk("bp_in_ready_back", in_ready, 1'b1);
        cyc();
        ready = 1'b1;
        cyc();

        // Gaps inside a codeword give the gap-free result.
        wg = N'($urandom());
        send_word(wg, 1'b1);
        chk("gap_syn", syndromes, eval_word(wg));
        send_word(wg, 1'b0);
        chk("nogap_syn", syndromes, eval_word(wg));

        // Reset mid-codeword discards the partial word.
        for (int i = 0; i < 7; i++) drive_bit(1'($urandom_range(0, 1)));
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("midrst_start", start, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        send_word(15'h4000, 1'b0);
        chk("midrst_syn", syndromes, 16'h1111);

        // Randomized words, gaps and downstream back-pressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) send_word(N'($urandom()), 1'($urandom_range(0, 1)));
        rnd_ready = 1'b0;
        cyc();
        ready = 1'b1;
        repeat (4) cyc();
        chk("final_idle_start", start, 1'b0);
        chk("final_in_ready", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
